nodf_module_intf: RTL and testbench

NODF_MODULE_INTF -- requirements
Module: nodf_module_intf

---
 rtl/nodf_module_intf.sv | 139 +++++++++++++
 tb/tb_nodf_module_intf.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nodf_module_intf.sv
// Handshake monitor for an ap_start/ap_ready/ap_done/ap_continue block.
// Ports: clock, reset (async, low); ap_* and finish in; state, counters, error out.
module nodf_module_intf #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic [CNT_W-1:0] last_interval,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             error
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN       = 2'b01,
    WAIT_CONT = 2'b10,
    FINISHED  = 2'b11
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] lat;
  logic [CNT_W-1:0] lat_nxt;
  logic [CNT_W-1:0] ival;
  logic [CNT_W-1:0] rec_val;
  logic             rec;
  logic             seen_start;
  logic             start_q;
  logic             start_acc;
  logic             done_ack;
  logic             stall;
  logic             err_ev;

  assign start_acc = ap_start & ap_ready;
  assign done_ack  = ap_done & ap_continue;
  assign stall     = ap_done & ~ap_continue;
  assign state     = cur;

  assign err_ev =
    ((cur == IDLE) & done_ack & ~ap_start) |
    ((cur == RUN) & ap_start & ~start_q &
     ~ap_ready & (done_cnt == start_cnt));

  // lat already includes the start cycle, so a
  // done on the following cycle reports 2.
  always_comb begin
    nxt     = cur;
    lat_nxt = lat;
    rec     = 1'b0;
    rec_val = '0;
    unique case (cur)
      IDLE: begin
        if (done_ack) begin
          if (ap_start) begin
            rec     = 1'b1;
            rec_val = '0;
          end
        end else if (ap_start) begin
          nxt     = RUN;
          lat_nxt = CNT_W'(1);
        end
      end
      RUN, WAIT_CONT: begin
        lat_nxt = sat_inc(lat);
        if (done_ack) begin
          rec     = 1'b1;
          rec_val = sat_inc(lat);
          if (ap_start) begin
            nxt     = RUN;
            lat_nxt = CNT_W'(1);
          end else begin
            nxt = IDLE;
          end
        end else if (ap_done) begin
          nxt = WAIT_CONT;
        end else begin
          nxt = RUN;
        end
      end
      FINISHED: begin
        nxt = FINISHED;
      end
    endcase
    if (finish) nxt = FINISHED;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur           <= IDLE;
      lat           <= '0;
      ival          <= '0;
      seen_start    <= 1'b0;
      start_q       <= 1'b0;
      start_cnt     <= '0;
      done_cnt      <= '0;
      last_latency  <= '0;
      max_latency   <= '0;
      last_interval <= '0;
      stall_cnt     <= '0;
      error         <= 1'b0;
    end else if (cur != FINISHED) begin
      cur     <= nxt;
      lat     <= lat_nxt;
      start_q <= ap_start;
      if (start_acc) begin
        start_cnt  <= sat_inc(start_cnt);
        ival       <= '0;
        seen_start <= 1'b1;
        if (seen_start) last_interval <= sat_inc(ival);
      end else begin
        ival <= sat_inc(ival);
      end
      if (done_ack) done_cnt <= sat_inc(done_cnt);
      if (stall) stall_cnt <= sat_inc(stall_cnt);
      if (rec) begin
        last_latency <= rec_val;
        if (rec_val > max_latency) max_latency <= rec_val;
      end
      if (err_ev) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nodf_module_intf.sv
// Directed scoreboard bench for nodf_module_intf.
// Narrow counters are used so saturation is reachable.
module tb_nodf_module_intf;

  localparam int W = 4;

  localparam int F_STATE = 0;
  localparam int F_START = 1;
  localparam int F_DONE  = 2;
  localparam int F_LAST  = 3;
  localparam int F_MAX   = 4;
  localparam int F_IVAL  = 5;
  localparam int F_STALL = 6;
  localparam int F_ERR   = 7;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         ap_start = 1'b0;
  logic         ap_ready = 1'b0;
  logic         ap_done = 1'b0;
  logic         ap_continue = 1'b0;
  logic         finish = 1'b0;
  logic [1:0]   state;
  logic [W-1:0] start_cnt;
  logic [W-1:0] done_cnt;
  logic [W-1:0] last_latency;
  logic [W-1:0] max_latency;
  logic [W-1:0] last_interval;
  logic [W-1:0] stall_cnt;
  logic         error;

  int compared = 0;
  int mism = 0;

  typedef struct {
    string        tag;
    int           sel;
    logic [W-1:0] val;
  } exp_t;

  exp_t sbq[$];

  nodf_module_intf #(.CNT_W(W)) dut (
    .clock(clock),
    .reset(reset),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_done(ap_done),
    .ap_continue(ap_continue),
    .finish(finish),
    .state(state),
    .start_cnt(start_cnt),
    .done_cnt(done_cnt),
    .last_latency(last_latency),
    .max_latency(max_latency),
    .last_interval(last_interval),
    .stall_cnt(stall_cnt),
    .error(error)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] get(input int sel);
    case (sel)
      F_STATE: return W'(state);
      F_START: return start_cnt;
      F_DONE:  return done_cnt;
      F_LAST:  return last_latency;
      F_MAX:   return max_latency;
      F_IVAL:  return last_interval;
      F_STALL: return stall_cnt;
      default: return W'(error);
    endcase
  endfunction

  task automatic push(input string tag,
                      input int sel,
                      input int v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = W'(v);
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [W-1:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = get(e.sel);
      compared++;
      assert (o === e.val) else begin
        mism++;
        $error("FAIL %s: observed %0d expected %0d",
               e.tag, o, e.val);
      end
    end
  endtask

  task automatic drive(input logic s, input logic r,
                       input logic d, input logic c,
                       input logic f);
    ap_start    = s;
    ap_ready    = r;
    ap_done     = d;
    ap_continue = c;
    finish      = f;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    drain();
  endtask

  task automatic push_zero(input string tag);
    for (int i = 0; i <= F_ERR; i++) push(tag, i, 0);
  endtask

  // Reset is applied between edges and checked without
  // any clock edge, so the clear must be asynchronous.
  task automatic do_reset(input string tag);
    @(negedge clock);
    #2;
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    push_zero(tag);
    drain();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #7;
    push_zero("por");
    drain();
    @(negedge clock);
    reset = 1'b1;

    // single transaction, done 5 cycles after start
    drive(1, 1, 0, 0, 0);
    push("a_run", F_STATE, 1);
    push("a_scnt", F_START, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (4) tick();
    drive(0, 0, 1, 1, 0);
    push("a_lat", F_LAST, 6);
    push("a_max", F_MAX, 6);
    push("a_dcnt", F_DONE, 1);
    push("a_idle", F_STATE, 0);
    push("a_err", F_ERR, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();

    // two starts 10 cycles apart, each done 3 later
    do_reset("rst_b");
    drive(1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (2) tick();
    drive(0, 0, 1, 1, 0);
    push("b_lat1", F_LAST, 4);
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (6) tick();
    drive(1, 1, 0, 0, 0);
    push("b_ival", F_IVAL, 10);
    push("b_scnt", F_START, 2);
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (2) tick();
    drive(0, 0, 1, 1, 0);
    push("b_lat2", F_LAST, 4);
    push("b_max", F_MAX, 4);
    push("b_dcnt", F_DONE, 2);
    tick();

    // four stall cycles then acknowledge
    do_reset("rst_c");
    drive(1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      push("c_wait", F_STATE, 2);
      tick();
    end
    drive(0, 0, 1, 1, 0);
    push("c_stall", F_STALL, 4);
    push("c_idle", F_STATE, 0);
    push("c_lat", F_LAST, 6);
    tick();

    // long stall: counters pin at all-ones
    do_reset("rst_s");
    drive(1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    repeat (20) tick();
    push("s_stall", F_STALL, 15);
    push("s_wait", F_STATE, 2);
    drain();
    drive(0, 0, 1, 1, 0);
    push("s_lat", F_LAST, 15);
    push("s_max", F_MAX, 15);
    tick();
    drive(1, 1, 0, 0, 0);
    push("s_ival", F_IVAL, 15);
    push("s_scnt", F_START, 2);
    tick();

    // done acknowledged in IDLE with no start
    do_reset("rst_d");
    drive(0, 0, 1, 1, 0);
    push("d_err", F_ERR, 1);
    push("d_dcnt", F_DONE, 1);
    push("d_idle", F_STATE, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    push("d_sticky", F_ERR, 1);
    tick();

    // start and done together in IDLE
    do_reset("rst_z");
    drive(1, 1, 1, 1, 0);
    push("z_idle", F_STATE, 0);
    push("z_lat", F_LAST, 0);
    push("z_err", F_ERR, 0);
    push("z_scnt", F_START, 1);
    push("z_dcnt", F_DONE, 1);
    tick();

    // start re-raised in RUN while not ready
    do_reset("rst_e");
    drive(1, 0, 0, 0, 0);
    push("e_run", F_STATE, 1);
    push("e_scnt", F_START, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    push("e_err0", F_ERR, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    push("e_err1", F_ERR, 1);
    tick();

    // finish pulse with a done in the same cycle
    do_reset("rst_f");
    drive(1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 1, 1);
    push("f_fin", F_STATE, 3);
    push("f_dcnt", F_DONE, 1);
    push("f_lat", F_LAST, 3);
    tick();
    drive(1, 1, 1, 0, 0);
    repeat (3) tick();
    drive(1, 1, 1, 1, 0);
    push("f_hold", F_STATE, 3);
    push("f_scnt", F_START, 1);
    push("f_dcnt2", F_DONE, 1);
    push("f_stall", F_STALL, 0);
    push("f_lat2", F_LAST, 3);
    tick();

    // reset in the middle of a transaction
    do_reset("rst_g");
    drive(1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    push("g_run", F_STATE, 1);
    push("g_scnt", F_START, 1);
    tick();
    do_reset("g_async");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
